// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit
// Issue-side hazard tracker for long-latency producers (loads with wait
// states, multi-cycle multiplier). It sits at ID, stalls on RAW/WAW
// against pending destinations or when the tracker is full, and retires
// entries on writeback.
// Optional feature macro: SCOREBOARD_WB_BYPASS_EN. When defined, a register
// retiring this cycle is treated as available because the regfile write-through
// supplies the value.
// stall is combinational; all other outputs are registered.

module scoreboard_hazard_unit #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic             issue_use_rs1,
    input  logic             issue_use_rs2,
    input  logic [4:0]       issue_rd,
    input  logic             issue_reg_wr,
    input  logic             issue_long,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    output logic             stall,
    output logic [CNT_W-1:0] outstanding,
    output logic [31:0]      pending_vec,
    output logic             sb_error
);

    logic             wb_err;
    logic             clr;
    logic [31:0]      pend_eff;
    logic             raw;
    logic             waw;
    logic             full;
    logic             set;
    logic [31:0]      pending_nxt;
    logic [CNT_W-1:0] outstanding_nxt;

    // Writeback classification: legal retirement vs. error (no state change on error)
    always_comb begin
        wb_err = wb_valid && (((wb_rd != 5'd0) && !pending_vec[wb_rd]) ||
                              (outstanding == CNT_W'(0)));
        clr    = wb_valid && (wb_rd != 5'd0) && pending_vec[wb_rd] && !wb_err;
    end

    // Effective pending view used by the hazard checks
    always_comb begin
`ifdef SCOREBOARD_WB_BYPASS_EN
        pend_eff = pending_vec & ~(clr ? (32'd1 << wb_rd) : 32'd0);
`else
        pend_eff = pending_vec;
`endif
    end

    // Hazard detection and issue decision; flush squashes both stall and set
    always_comb begin
        raw   = (issue_use_rs1 && (issue_rs1 != 5'd0) && pend_eff[issue_rs1]) ||
                (issue_use_rs2 && (issue_rs2 != 5'd0) && pend_eff[issue_rs2]);
        waw   = issue_reg_wr && (issue_rd != 5'd0) && pend_eff[issue_rd];
        full  = issue_long && issue_reg_wr && (issue_rd != 5'd0) &&
                (outstanding == CNT_W'(MAX_OUTSTANDING));
        stall = issue_valid && !flush && (raw || waw || full);
        set   = issue_valid && !flush && !stall &&
                issue_long && issue_reg_wr && (issue_rd != 5'd0);
    end

    // Next-state: clear first so a same-register set wins
    always_comb begin
        pending_nxt = pending_vec;
        if (clr) begin
            pending_nxt[wb_rd] = 1'b0;
        end
        if (set) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;

        outstanding_nxt = outstanding;
        case ({set, clr})
            2'b10:   outstanding_nxt = outstanding + CNT_W'(1);
            2'b01:   outstanding_nxt = outstanding - CNT_W'(1);
            default: outstanding_nxt = outstanding;
        endcase
    end

    // State registers with synchronous reset; sb_error is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_vec <= 32'd0;
            outstanding <= CNT_W'(0);
            sb_error    <= 1'b0;
        end else begin
            pending_vec <= pending_nxt;
            outstanding <= outstanding_nxt;
            sb_error    <= sb_error | wb_err;
        end
    end

endmodule
